// File: rtl/calc_entry.sv
// Keypad operand/operator entry controller driving the BCD arithmetic unit.
// Optional backspace key (0xE) enabled by defining CALC_ENTRY_BACKSPACE_EN.
module calc_entry (
    input  logic        clk,
    input  logic        clear,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [15:0] bcd1,
    output logic [15:0] bcd2,
    output logic [1:0]  op_selected,
    output logic [1:0]  alu_enable,
    output logic [1:0]  digit_count,
    output logic [1:0]  disp_sel
);

    typedef enum logic [1:0] {
        S_OP1,
        S_OP2,
        S_CALC,
        S_RESULT
    } state_t;

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_EQ  = 4'hC;
    localparam logic [3:0] K_CE  = 4'hD;
    localparam logic [3:0] K_BS  = 4'hE;
    localparam logic [3:0] K_AC  = 4'hF;

    state_t      state_q, state_d;
    logic [15:0] bcd1_q, bcd1_d;
    logic [15:0] bcd2_q, bcd2_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  alu_q, alu_d;
    logic [1:0]  disp_q, disp_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic        is_digit;
    logic        in_entry;
    logic [15:0] opnd;
    logic [15:0] opnd_new;
    logic        opnd_wr;
    logic [1:0]  key_op;

    assign accept   = key_valid && ready_q;
    assign is_digit = (key_code <= 4'd9);
    assign in_entry = (state_q == S_OP1) || (state_q == S_OP2);
    assign opnd     = (state_q == S_OP1) ? bcd1_q : bcd2_q;
    assign key_op   = (key_code == K_ADD) ? 2'b01 : 2'b10;

    always_comb begin
        state_d  = state_q;
        bcd1_d   = bcd1_q;
        bcd2_d   = bcd2_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opnd_new = opnd;
        opnd_wr  = 1'b0;

        if (state_q == S_CALC) begin
            state_d = S_RESULT;
        end else if (accept && in_entry) begin
            if (is_digit) begin
                // No leading zeros and no growth past three digits.
                if (cnt_q != 2'd3 && !(cnt_q == 2'd0 && key_code == 4'd0)) begin
                    opnd_new = {4'h0, opnd[7:0], key_code};
                    opnd_wr  = 1'b1;
                    cnt_d    = cnt_q + 2'd1;
                end
            end else begin
                case (key_code)
                    K_ADD, K_SUB: begin
                        if (state_q == S_OP1) begin
                            op_d    = key_op;
                            bcd2_d  = 16'h0;
                            cnt_d   = 2'd0;
                            state_d = S_OP2;
                        end else if (cnt_q == 2'd0) begin
                            op_d = key_op;
                        end
                    end
                    K_EQ: begin
                        if (state_q == S_OP2) state_d = S_CALC;
                    end
                    K_CE: begin
                        opnd_new = 16'h0;
                        opnd_wr  = 1'b1;
                        cnt_d    = 2'd0;
                    end
`ifdef CALC_ENTRY_BACKSPACE_EN
                    K_BS: begin
                        if (cnt_q != 2'd0) begin
                            opnd_new = {8'h0, opnd[11:4]};
                            opnd_wr  = 1'b1;
                            cnt_d    = cnt_q - 2'd1;
                        end
                    end
`endif
                    K_AC: begin
                        state_d = S_OP1;
                        bcd1_d  = 16'h0;
                        bcd2_d  = 16'h0;
                        op_d    = 2'b00;
                        cnt_d   = 2'd0;
                    end
                    default: ;
                endcase
            end
            if (opnd_wr) begin
                if (state_q == S_OP1) bcd1_d = opnd_new;
                else bcd2_d = opnd_new;
            end
        end else if (accept && state_q == S_RESULT) begin
            if (is_digit) begin
                state_d = S_OP1;
                bcd1_d  = {12'h0, key_code};
                bcd2_d  = 16'h0;
                op_d    = 2'b00;
                cnt_d   = (key_code == 4'd0) ? 2'd0 : 2'd1;
            end else if (key_code == K_CE || key_code == K_AC) begin
                state_d = S_OP1;
                bcd1_d  = 16'h0;
                bcd2_d  = 16'h0;
                op_d    = 2'b00;
                cnt_d   = 2'd0;
            end
        end

        // Strobes and display select are registered from the next state.
        alu_d   = (state_d == S_CALC) ? 2'b01 : 2'b00;
        ready_d = (state_d != S_CALC);
        case (state_d)
            S_OP1:   disp_d = 2'b00;
            S_OP2:   disp_d = 2'b01;
            default: disp_d = 2'b10;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= S_OP1;
            bcd1_q  <= 16'h0;
            bcd2_q  <= 16'h0;
            op_q    <= 2'b00;
            cnt_q   <= 2'd0;
            alu_q   <= 2'b00;
            disp_q  <= 2'b00;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            bcd1_q  <= bcd1_d;
            bcd2_q  <= bcd2_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            disp_q  <= disp_d;
            ready_q <= ready_d;
        end
    end

    assign key_ready   = ready_q;
    assign bcd1        = bcd1_q;
    assign bcd2        = bcd2_q;
    assign op_selected = op_q;
    assign alu_enable  = alu_q;
    assign digit_count = cnt_q;
    assign disp_sel    = disp_q;

endmodule

// File: tb/tb_calc_entry.sv
// Randomized bench for calc_entry against a decimal-valued reference model.
// Honours CALC_ENTRY_BACKSPACE_EN the same way as the design.
module tb_calc_entry;

    logic        clk = 1'b0;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [15:0] bcd1;
    logic [15:0] bcd2;
    logic [1:0]  op_selected;
    logic [1:0]  alu_enable;
    logic [1:0]  digit_count;
    logic [1:0]  disp_sel;

    int total = 0;
    int bad   = 0;

    localparam int M_OP1 = 0;
    localparam int M_OP2 = 1;
    localparam int M_CALC = 2;
    localparam int M_RES = 3;

    int m_mode, m_v1, m_v2, m_op, m_cnt;

    calc_entry dut (
        .clk         (clk),
        .clear       (clear),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .bcd1        (bcd1),
        .bcd2        (bcd2),
        .op_selected (op_selected),
        .alu_enable  (alu_enable),
        .digit_count (digit_count),
        .disp_sel    (disp_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic m_reset();
        m_mode = M_OP1;
        m_v1 = 0;
        m_v2 = 0;
        m_op = 0;
        m_cnt = 0;
    endtask

    task automatic m_key(input int code);
        int v;
        v = (m_mode == M_OP1) ? m_v1 : m_v2;
        if (m_mode == M_RES) begin
            if (code <= 9) begin
                m_v1 = code;
                m_v2 = 0;
                m_op = 0;
                m_cnt = (code != 0) ? 1 : 0;
                m_mode = M_OP1;
            end else if (code == 13 || code == 15) begin
                m_reset();
            end
            return;
        end
        if (code <= 9) begin
            if (m_cnt < 3 && !(m_cnt == 0 && code == 0)) begin
                v = v * 10 + code;
                m_cnt++;
            end
        end else if (code == 10 || code == 11) begin
            if (m_mode == M_OP1) begin
                m_op = code - 9;
                m_v2 = 0;
                m_cnt = 0;
                m_mode = M_OP2;
                return;
            end else if (m_cnt == 0) begin
                m_op = code - 9;
            end
        end else if (code == 12) begin
            if (m_mode == M_OP2) m_mode = M_CALC;
            return;
        end else if (code == 13) begin
            v = 0;
            m_cnt = 0;
        end else if (code == 14) begin
`ifdef CALC_ENTRY_BACKSPACE_EN
            if (m_cnt > 0) begin
                v = v / 10;
                m_cnt--;
            end
`endif
        end else begin
            m_reset();
            return;
        end
        if (m_mode == M_OP1) m_v1 = v;
        else m_v2 = v;
    endtask

    task automatic m_edge(input bit clr, input bit vld, input int code);
        if (!clr) m_reset();
        else if (m_mode == M_CALC) m_mode = M_RES;
        else if (vld) m_key(code);
    endtask

    task automatic check_all();
        chk("bcd1", bcd1, to_bcd(m_v1));
        chk("bcd2", bcd2, to_bcd(m_v2));
        chk("op", op_selected, m_op);
        chk("cnt", digit_count, m_cnt);
        chk("alu", alu_enable, (m_mode == M_CALC) ? 1 : 0);
        chk("ready", key_ready, (m_mode != M_CALC) ? 1 : 0);
        chk("disp", disp_sel, (m_mode == M_OP1) ? 0 : (m_mode == M_OP2) ? 1 : 2);
    endtask

    task automatic step(input bit clr, input bit vld, input int code);
        @(negedge clk);
        clear = clr;
        key_valid = vld;
        key_code = 4'(code);
        @(posedge clk);
        m_edge(clr, vld, code);
        #1;
        check_all();
    endtask

    task automatic key(input int code);
        step(1'b1, 1'b1, code);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 0);
    endtask

    initial begin
        clear = 1'b0;
        key_valid = 1'b0;
        key_code = 4'h0;
        m_reset();
        step(1'b0, 1'b0, 0);
        chk("rst_bcd1", bcd1, 16'h0000);
        chk("rst_ready", key_ready, 1);

        key(1); key(2); key(3); key(10); key(4); key(5);
        chk("d_bcd1", bcd1, 16'h0123);
        chk("d_bcd2", bcd2, 16'h0045);
        chk("d_op", op_selected, 2'b01);
        key(12);
        chk("d_alu_on", alu_enable, 2'b01);
        idle();
        chk("d_alu_off", alu_enable, 2'b00);
        chk("d_disp", disp_sel, 2'b10);

        key(6);
        chk("r_bcd1", bcd1, 16'h0006);
        chk("r_op", op_selected, 2'b00);
        step(1'b0, 1'b0, 0);

        key(9); key(8); key(7); key(6);
        chk("max_bcd1", bcd1, 16'h0987);
        chk("max_cnt", digit_count, 2'd3);
        key(15); key(0); key(0); key(5);
        chk("lz_bcd1", bcd1, 16'h0005);
        chk("lz_cnt", digit_count, 2'd1);

        key(15); key(7); key(10); key(11); key(3); key(12);
        chk("sub_op", op_selected, 2'b10);
        chk("sub_bcd2", bcd2, 16'h0003);
        key(9);
        chk("drop_bcd1", bcd1, 16'h0007);
        key(15); key(2); key(10); key(1); key(12);
        step(1'b0, 1'b0, 0);
        chk("clr_alu", alu_enable, 2'b00);
        step(1'b0, 1'b1, 5);
        chk("clrkey_bcd1", bcd1, 16'h0000);

        key(3); key(10); key(4); key(13);
        chk("ce_bcd1", bcd1, 16'h0003);
        chk("ce_bcd2", bcd2, 16'h0000);

        key(15); key(4); key(5); key(6); key(14);
`ifdef CALC_ENTRY_BACKSPACE_EN
        chk("bs_bcd1", bcd1, 16'h0045);
        chk("bs_cnt", digit_count, 2'd2);
`else
        chk("bs_bcd1", bcd1, 16'h0456);
        chk("bs_cnt", digit_count, 2'd3);
`endif

        for (int i = 0; i < 3000; i++) begin
            bit clr;
            bit vld;
            int code;
            clr = ($urandom_range(0, 99) >= 2);
            vld = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0) code = $urandom_range(10, 15);
            else code = $urandom_range(0, 9);
            step(clr, vld, code);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
